// File: rtl/dwt_line_trim.sv
// dwt_line_trim: drops the filter warm-up beats at the start of every DWT line,
// re-tags frame start on the first surviving beat and reports per-line lengths.
module dwt_line_trim #(
  parameter int DataWidth    = 16,
  parameter int Lanes        = 2,
  parameter int SkipBeats    = 4,
  parameter int MaxLineBeats = 512,
  localparam int LenW        = $clog2(MaxLineBeats + 1),
  localparam int BeatW       = Lanes * DataWidth
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             bypass_i,
  output logic             s_ready_o,
  input  logic             s_valid_i,
  input  logic             s_sof_i,
  input  logic             s_eol_i,
  input  logic [BeatW-1:0] s_data_i,
  input  logic             m_ready_i,
  output logic             m_valid_o,
  output logic             m_sof_o,
  output logic             m_eol_o,
  output logic [BeatW-1:0] m_data_o,
  output logic [LenW-1:0]  line_len_o,
  output logic             line_len_valid_o,
  output logic             short_line_o
);

  localparam logic [3:0]      SkipLim = 4'(SkipBeats);
  localparam logic [LenW-1:0] LenMax  = LenW'(MaxLineBeats);
  localparam logic [LenW-1:0] LenOne  = LenW'(1);
  localparam logic [LenW-1:0] LenZero = LenW'(0);

  logic [3:0]       skip_cnt_r;
  logic [LenW-1:0]  kept_cnt_r;
  logic             sof_pend_r;
  logic             line_byp_r;
  logic             out_vld_r, out_sof_r, out_eol_r;
  logic [BeatW-1:0] out_data_r;
  logic             skid_vld_r, skid_sof_r, skid_eol_r;
  logic [BeatW-1:0] skid_data_r;
  logic [LenW-1:0]  line_len_r;
  logic             len_vld_r;
  logic             short_r;

  logic             first_beat_s, byp_eff_s, drop_s, ready_s;
  logic             accept_s, push_s, pop_s, tag_sof_s;
  logic [3:0]       skip_nxt_s;
  logic [LenW-1:0]  kept_inc_s;

  // Keep/drop decision for the beat currently on the input, plus handshakes
  always_comb begin
    first_beat_s = (skip_cnt_r == 4'd0) && (kept_cnt_r == LenZero);
    byp_eff_s    = first_beat_s ? bypass_i : line_byp_r;
    drop_s       = !byp_eff_s && (skip_cnt_r < SkipLim);
    // Drops never touch the buffer, so they are accepted regardless of m_ready_i
    ready_s      = !rst_i && (drop_s || !skid_vld_r);
    accept_s     = s_valid_i && ready_s;
    push_s       = accept_s && !drop_s;
    pop_s        = out_vld_r && m_ready_i;
    tag_sof_s    = sof_pend_r || s_sof_i;
    if (skip_cnt_r < SkipLim) begin
      skip_nxt_s = skip_cnt_r + 4'd1;
    end else begin
      skip_nxt_s = skip_cnt_r;
    end
    if (kept_cnt_r < LenMax) begin
      kept_inc_s = kept_cnt_r + LenOne;
    end else begin
      kept_inc_s = LenMax;
    end
  end

  // Line tracking: skip window, bypass latch, pending sof and kept-beat count
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      skip_cnt_r <= 4'd0;
      kept_cnt_r <= LenZero;
      sof_pend_r <= 1'b0;
      line_byp_r <= 1'b0;
    end else if (accept_s) begin
      skip_cnt_r <= s_eol_i ? 4'd0 : skip_nxt_s;
      if (first_beat_s) begin
        line_byp_r <= bypass_i;
      end
      sof_pend_r <= drop_s ? tag_sof_s : 1'b0;
      if (s_eol_i) begin
        kept_cnt_r <= LenZero;
      end else if (push_s) begin
        kept_cnt_r <= kept_inc_s;
      end
    end
  end

  // Length and short-line strobes, one cycle after the input-side accept
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      line_len_r <= LenZero;
      len_vld_r  <= 1'b0;
      short_r    <= 1'b0;
    end else begin
      len_vld_r <= push_s && s_eol_i;
      short_r   <= accept_s && drop_s && s_eol_i;
      if (push_s && s_eol_i) begin
        line_len_r <= kept_inc_s;
      end
    end
  end

  // Two-entry skid buffer: output register backed by one skid register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_vld_r   <= 1'b0;
      out_sof_r   <= 1'b0;
      out_eol_r   <= 1'b0;
      out_data_r  <= {BeatW{1'b0}};
      skid_vld_r  <= 1'b0;
      skid_sof_r  <= 1'b0;
      skid_eol_r  <= 1'b0;
      skid_data_r <= {BeatW{1'b0}};
    end else if (!out_vld_r || pop_s) begin
      if (skid_vld_r) begin
        out_vld_r  <= 1'b1;
        out_sof_r  <= skid_sof_r;
        out_eol_r  <= skid_eol_r;
        out_data_r <= skid_data_r;
        skid_vld_r <= push_s;
        if (push_s) begin
          skid_sof_r  <= tag_sof_s;
          skid_eol_r  <= s_eol_i;
          skid_data_r <= s_data_i;
        end
      end else begin
        out_vld_r <= push_s;
        if (push_s) begin
          out_sof_r  <= tag_sof_s;
          out_eol_r  <= s_eol_i;
          out_data_r <= s_data_i;
        end
      end
    end else if (push_s) begin
      skid_vld_r  <= 1'b1;
      skid_sof_r  <= tag_sof_s;
      skid_eol_r  <= s_eol_i;
      skid_data_r <= s_data_i;
    end
  end

  assign s_ready_o        = ready_s;
  assign m_valid_o        = out_vld_r;
  assign m_sof_o          = out_sof_r;
  assign m_eol_o          = out_eol_r;
  assign m_data_o         = out_data_r;
  assign line_len_o       = line_len_r;
  assign line_len_valid_o = len_vld_r;
  assign short_line_o     = short_r;

endmodule
